prompt_sequencer: RTL
=====================

Name: prompt_sequencer

Overview:
Downstream consumer of the 3-bit LFSR in the NotNot game datapath. Pulls one pseudo-random value per round and decodes it into a prompt: a direction, optionally prefixed by "NOT". Times the player's response window, judges the key press, and maintains score and lives. Drives the LFSR's enable and feeds the display and score stages.

Parameters:
TIMEOUT_CYCLES, 50000000, initial response window in clock cycles (1 s at 50 MHz)
TIMEOUT_STEP, 2500000, cycles removed from window after each hit
TIMEOUT_MIN, 12500000, floor on the response window
RESULT_CYCLES, 12500000, hold time between rounds
TIMER_W, 26, width of window/timer registers
SCORE_W, 8, score width
START_LIVES, 3, lives loaded at game start (1..3)

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  single-cycle pulse; begins a game from IDLE or GAME_OVER
lfsr_in  in  3  value from LFSR
key_valid  in  1  single-cycle pulse; player pressed a key
key_dir  in  2  pressed direction (0 up, 1 right, 2 down, 3 left)
lfsr_enable  out  1  advance request to LFSR
prompt_valid  out  1  prompt is live (SHOW state)
prompt_dir  out  2  prompt direction
prompt_not  out  1  prompt is negated
timer_remaining  out  TIMER_W  cycles left in current window
score  out  SCORE_W  hits this game
lives  out  2  remaining lives
hit  out  1  one-cycle pulse on a correct answer
miss  out  1  one-cycle pulse on a wrong answer or timeout
game_over  out  1  high in GAME_OVER

Behaviour:
- Reset (async): state IDLE; all outputs 0, including lives, score, and timer; window register = TIMEOUT_CYCLES.
- States: IDLE, FETCH, SAMPLE, SHOW, RESULT, GAME_OVER.
- IDLE / GAME_OVER:
  - start -> FETCH; score <= 0; lives <= START_LIVES; window <= TIMEOUT_CYCLES.
  - game_over = 1 in GAME_OVER only. score and lives are held there.
- FETCH: lfsr_enable = 1 (decoded from state, exactly one cycle) -> SAMPLE.
- SAMPLE: capture lfsr_in (LFSR has advanced on the FETCH edge).
  - prompt_dir <= lfsr_in[1:0]; prompt_not <= lfsr_in[2].
  - lfsr_in == 3'b111 is invalid -> FETCH again; prompt registers are not updated.
  - Otherwise timer_remaining <= window -> SHOW.
- SHOW: prompt_valid = 1; timer_remaining decrements by 1 each cycle.
  - Correct key: prompt_not=0 requires key_dir == prompt_dir; prompt_not=1 requires key_dir != prompt_dir.
  - key_valid and correct: hit pulse; score +1, saturating at all-ones; window <= max(window - TIMEOUT_STEP, TIMEOUT_MIN) with no underflow; -> RESULT.
  - key_valid and wrong: miss pulse; lives -1 -> RESULT.
  - No key with timer_remaining == 1: miss; lives -1 -> RESULT. A window of W gives exactly W SHOW cycles.
  - key_valid in the final timer cycle is judged; the key takes priority over the timeout.
- RESULT: prompt_valid = 0; prompt registers held; counter runs RESULT_CYCLES cycles, then -> GAME_OVER if lives == 0, else -> FETCH.
- Ignored inputs:
  - key_valid outside SHOW.
  - start outside IDLE/GAME_OVER.
  - lfsr_in outside SAMPLE.
- hit and miss are never high together; each is high for exactly one cycle per round.
- Reset mid-round: immediate return to the reset state with no further pulses.

Test Plan:
All scenarios use TIMEOUT_CYCLES=8, TIMEOUT_STEP=2, TIMEOUT_MIN=4, RESULT_CYCLES=2, START_LIVES=2.
1. Start: reset, start pulse, lfsr_in=3'b010 -> lfsr_enable high exactly 1 cycle; then prompt_valid=1, prompt_dir=2, prompt_not=0, timer_remaining=8, lives=2.
2. Hit and window shrink: key_dir=2 during SHOW -> hit pulse, score=1; next three rounds answered correctly give timer start values 6, 4, 4.
3. Negated prompt: lfsr_in=3'b101 -> prompt_dir=1, prompt_not=1. key_dir=1 -> miss, lives=1. Next round with the same prompt, key_dir=3 -> hit.
4. Timeout to game over: no key for 8 SHOW cycles -> miss on 8th edge, lives 2->1. Repeat -> lives=0, game_over=1 after 2 RESULT cycles. Another start pulse -> score=0, lives=2.
5. Invalid value: lfsr_in=3'b111 in SAMPLE -> second lfsr_enable pulse, no prompt_valid. Then 3'b000 -> prompt_dir=0.
6. Edge and reset: key_valid with the correct key when timer_remaining=1 -> hit, no miss. Reset asserted mid-SHOW -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/prompt_sequencer.sv
// Prompt sequencer for the NotNot game: pulls an LFSR value per round,
// decodes it into a (possibly negated) direction prompt, times the player's
// response window, judges the key press and keeps score and lives.
// Ports: clock/reset (async, active-high); start begins a game; lfsr_in is
// the LFSR value and lfsr_enable advances it; key_valid/key_dir carry the
// player's key; prompt_valid/prompt_dir/prompt_not describe the live prompt;
// timer_remaining counts down the window; score/lives track the game;
// hit/miss pulse once per round; game_over is high in GAME_OVER.
module prompt_sequencer #(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int TIMEOUT_STEP   = 2500000,
    parameter int TIMEOUT_MIN    = 12500000,
    parameter int RESULT_CYCLES  = 12500000,
    parameter int TIMER_W        = 26,
    parameter int SCORE_W        = 8,
    parameter int START_LIVES    = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         lfsr_in,
    input  logic               key_valid,
    input  logic [1:0]         key_dir,
    output logic               lfsr_enable,
    output logic               prompt_valid,
    output logic [1:0]         prompt_dir,
    output logic               prompt_not,
    output logic [TIMER_W-1:0] timer_remaining,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               hit,
    output logic               miss,
    output logic               game_over
);

    typedef enum logic [2:0] {
        IDLE, FETCH, SAMPLE, SHOW, RESULT, GAME_OVER
    } state_t;

    localparam logic [TIMER_W-1:0] WIN_INIT = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] WIN_STEP = TIMER_W'(TIMEOUT_STEP);
    localparam logic [TIMER_W-1:0] WIN_MIN  = TIMER_W'(TIMEOUT_MIN);
    localparam logic [TIMER_W-1:0] RES_LAST = TIMER_W'(RESULT_CYCLES - 1);
    localparam logic [1:0]         LIVES0   = 2'(START_LIVES);

    state_t             state, state_next;
    logic [TIMER_W-1:0] window;
    logic [TIMER_W-1:0] window_shrunk;
    logic [TIMER_W-1:0] result_cnt;
    logic               correct;
    logic               timeout;
    logic               lfsr_ok;
    logic               result_done;

    // A negated prompt accepts any direction except the shown one.
    assign correct     = prompt_not ? (key_dir != prompt_dir)
                                    : (key_dir == prompt_dir);
    assign timeout     = (timer_remaining == TIMER_W'(1));
    assign lfsr_ok     = (lfsr_in != 3'b111);
    assign result_done = (result_cnt == RES_LAST);

    // Shrink the window without wrapping below zero or below the floor.
    assign window_shrunk =
        ((window >= WIN_STEP) && ((window - WIN_STEP) >= WIN_MIN))
        ? (window - WIN_STEP) : WIN_MIN;

    always_comb begin
        state_next   = state;
        lfsr_enable  = 1'b0;
        prompt_valid = 1'b0;
        game_over    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                lfsr_enable = 1'b1;
                state_next  = SAMPLE;
            end
            SAMPLE: begin
                state_next = lfsr_ok ? SHOW : FETCH;
            end
            SHOW: begin
                prompt_valid = 1'b1;
                if (key_valid || timeout) state_next = RESULT;
            end
            RESULT: begin
                if (result_done)
                    state_next = (lives == 2'd0) ? GAME_OVER : FETCH;
            end
            GAME_OVER: begin
                game_over = 1'b1;
                if (start) state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            window          <= WIN_INIT;
            result_cnt      <= '0;
            timer_remaining <= '0;
            score           <= '0;
            lives           <= 2'd0;
            prompt_dir      <= 2'd0;
            prompt_not      <= 1'b0;
            hit             <= 1'b0;
            miss            <= 1'b0;
        end else begin
            state <= state_next;
            hit   <= 1'b0;
            miss  <= 1'b0;
            case (state)
                IDLE, GAME_OVER: begin
                    if (start) begin
                        score  <= '0;
                        lives  <= LIVES0;
                        window <= WIN_INIT;
                    end
                end
                SAMPLE: begin
                    if (lfsr_ok) begin
                        prompt_dir      <= lfsr_in[1:0];
                        prompt_not      <= lfsr_in[2];
                        timer_remaining <= window;
                    end
                end
                SHOW: begin
                    timer_remaining <= timer_remaining - TIMER_W'(1);
                    result_cnt      <= '0;
                    // A key in the last cycle wins over the timeout.
                    if (key_valid && correct) begin
                        hit    <= 1'b1;
                        window <= window_shrunk;
                        if (score != '1) score <= score + SCORE_W'(1);
                    end else if (key_valid || timeout) begin
                        miss <= 1'b1;
                        if (lives != 2'd0) lives <= lives - 2'd1;
                    end
                end
                RESULT: begin
                    result_cnt <= result_cnt + TIMER_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
